seg_scan_ctrl: RTL



---
 rtl/seg_scan_ctrl.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed scan controller for a common-anode
// multi-digit seven-segment display, with an all-off guard gap between
// digits, leading-zero blanking and a double-buffered (shadow/display) value.
//
// Ports:
//   clk, rst     system clock, asynchronous active-high reset
//   load         strobe: capture value_in/dp_in into the shadow register
//   value_in     packed BCD, nibble i = digit i (digit 0 rightmost)
//   dp_in        decimal-point enables, bit i = digit i
//   lz_en        leading-zero suppression enable (live)
//   an           digit anodes, active-low
//   seg          segments {g,f,e,d,c,b,a}, active-low
//   dp_n         decimal point, active-low
//   pending      shadow holds data not yet displayed
//   frame_done   one-cycle pulse when display is reloaded at a frame boundary
//
// state  | meaning
// -------+---------------------------------------------------------
// ST_GAP | guard gap, all anodes off, BLANK_CYC cycles
// ST_ON  | anode idx low, segments from digit idx, REFRESH_DIV-BLANK_CYC cycles

module seg_scan_ctrl #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int BLANK_CYC   = 500
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    lz_en,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp_n,
  output logic                    pending,
  output logic                    frame_done
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] GAP_LAST = CW'(BLANK_CYC - 1);
  localparam logic [CW-1:0] ON_LAST  = CW'(REFRESH_DIV - BLANK_CYC - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  typedef enum logic {ST_GAP, ST_ON} state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
  logic [4*NUM_DIGITS-1:0] disp_q, disp_d;
  logic [NUM_DIGITS-1:0]   dps_q, dps_d;
  logic [NUM_DIGITS-1:0]   dpd_q, dpd_d;
  logic                    pending_q, pending_d;
  logic                    fd_q, fd_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dpn_q, dpn_d;

  logic                    boundary;
  logic                    run_zero;
  logic [NUM_DIGITS-1:0]   zero_above;
  logic [3:0]              nib;
  logic                    suppress;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] n);
    case (n)
      4'd0:    bcd_to_seg = 7'b1000000;
      4'd1:    bcd_to_seg = 7'b1111001;
      4'd2:    bcd_to_seg = 7'b0100100;
      4'd3:    bcd_to_seg = 7'b0110000;
      4'd4:    bcd_to_seg = 7'b0011001;
      4'd5:    bcd_to_seg = 7'b0010010;
      4'd6:    bcd_to_seg = 7'b0000010;
      4'd7:    bcd_to_seg = 7'b1111000;
      4'd8:    bcd_to_seg = 7'b0000000;
      4'd9:    bcd_to_seg = 7'b0011000;
      default: bcd_to_seg = 7'b1111111;
    endcase
  endfunction

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + 1'b1;
    idx_d    = idx_q;
    boundary = 1'b0;
    case (state_q)
      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = ST_ON;
          cnt_d   = '0;
        end
      end
      default: begin
        if (cnt_q == ON_LAST) begin
          state_d = ST_GAP;
          cnt_d   = '0;
          if (idx_q == IDX_LAST) begin
            idx_d    = '0;
            boundary = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
    endcase

    // Display only reloads when leaving the last digit, so a frame never tears.
    disp_d = disp_q;
    dpd_d  = dpd_q;
    if (boundary && pending_q) begin
      disp_d = shadow_q;
      dpd_d  = dps_q;
    end
    fd_d = boundary && pending_q;

    // A load on the boundary edge lands in the shadow after the transfer above
    // has already taken the old shadow, so it must keep pending set.
    shadow_d  = shadow_q;
    dps_d     = dps_q;
    pending_d = pending_q;
    if (boundary) pending_d = 1'b0;
    if (load) begin
      shadow_d  = value_in;
      dps_d     = dp_in;
      pending_d = 1'b1;
    end

    // zero_above[i]: nibbles i..NUM_DIGITS-1 of the next display value are all 0
    zero_above = '0;
    run_zero   = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      run_zero      = run_zero & (disp_d[4*i +: 4] == 4'd0);
      zero_above[i] = run_zero;
    end

    nib      = disp_d[{idx_d, 2'b00} +: 4];
    suppress = lz_en && (idx_d != '0) && zero_above[idx_d];

    // Outputs are computed from the next state so they change on the same
    // edge as the state they reflect.
    an_d  = '1;
    seg_d = 7'h7F;
    dpn_d = 1'b1;
    if (state_d == ST_ON) begin
      an_d[idx_d] = 1'b0;
      seg_d       = suppress ? 7'h7F : bcd_to_seg(nib);
      dpn_d       = ~dpd_d[idx_d];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_GAP;
      cnt_q     <= '0;
      idx_q     <= '0;
      shadow_q  <= '0;
      disp_q    <= '0;
      dps_q     <= '0;
      dpd_q     <= '0;
      pending_q <= 1'b0;
      fd_q      <= 1'b0;
      an_q      <= '1;
      seg_q     <= 7'h7F;
      dpn_q     <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shadow_q  <= shadow_d;
      disp_q    <= disp_d;
      dps_q     <= dps_d;
      dpd_q     <= dpd_d;
      pending_q <= pending_d;
      fd_q      <= fd_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
      dpn_q     <= dpn_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp_n       = dpn_q;
  assign pending    = pending_q;
  assign frame_done = fd_q;

endmodule
